// File: rtl/pet_pkg.sv
// Shared types for the pet-status engine: FSM state codes, meter type and
// the saturating meter increment.
package pet_pkg;

    localparam int METER_W      = 7;
    localparam int DEATH_STAGES = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_AWAKE  = 3'd1;
    localparam state_t ST_ASLEEP = 3'd2;
    localparam state_t ST_DYING  = 3'd3;
    localparam state_t ST_DEAD   = 3'd4;

    typedef logic [METER_W-1:0] meter_t;

    typedef struct packed {
        meter_t hunger;
        meter_t bored;
        meter_t filth;
        meter_t sick;
    } meters_t;

    function automatic meter_t sat_inc(input meter_t m, input meter_t limit);
        return (m >= limit) ? limit : m + 1'b1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running game-tick prescaler: tick is high for one clk cycle out of
// every TICK_DIV, while the counter sits at TICK_DIV-1.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pet_stats.sv
// Pet-status engine: ages the pet, runs day/night, accumulates care meters
// and the dying countdown. Optional old-age death via `PET_OLD_AGE_EN.
module pet_stats
    import pet_pkg::*;
#(
    parameter int     TICK_DIV     = 50_000_000,
    parameter meter_t METER_MAX    = 7'd100,
    parameter meter_t THRESH       = 7'd60,
    parameter int     RATE_HUNGER  = 4,
    parameter int     RATE_BORED   = 6,
    parameter int     RATE_FILTH   = 8,
    parameter int     DAY_TICKS    = 120,
    parameter int     SLEEP_TICKS  = 20,
    parameter int     BUBBLE_TICKS = 15,
    parameter int     DYING_TICKS  = 10
`ifdef PET_OLD_AGE_EN
    ,
    parameter logic [7:0] MAX_AGE  = 8'd30
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       foodGiven,
    input  logic       ballGiven,
    input  logic       broomGiven,
    input  logic       pillsGiven,
    input  logic       firstAidGiven,
    output logic       sleep,
    output logic       hungry,
    output logic       boredom,
    output logic       filthy,
    output logic       illness,
    output logic       pet_dying,
    output logic       deceased,
    output logic [3:0] deathValue,
    output logic       removeBubble,
    output logic [7:0] age
);

    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

    logic    tick;
    state_t  state, state_n;
    meters_t meters, meters_n;
    cnt_t    hun_div, hun_div_n, bor_div, bor_div_n, fil_div, fil_div_n;
    cnt_t    day_cnt, day_cnt_n, dying_cnt, dying_cnt_n, bub_cnt, bub_cnt_n;
    logic [3:0] dv_n;
    logic [7:0] age_n;
    logic       bubble_n;
    logic       any_flag;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign any_flag = hungry | boredom | filthy | illness;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_n     = state;
        meters_n    = meters;
        hun_div_n   = hun_div;
        bor_div_n   = bor_div;
        fil_div_n   = fil_div;
        day_cnt_n   = day_cnt;
        dying_cnt_n = dying_cnt;
        bub_cnt_n   = bub_cnt;
        dv_n        = deathValue;
        age_n       = age;
        bubble_n    = 1'b0;

        case (state)
            ST_IDLE, ST_DEAD: begin
                if (go) begin
                    state_n     = ST_AWAKE;
                    meters_n    = '0;
                    hun_div_n   = '0;
                    bor_div_n   = '0;
                    fil_div_n   = '0;
                    day_cnt_n   = '0;
                    dying_cnt_n = '0;
                    dv_n        = '0;
                    age_n       = '0;
                end
            end
            ST_AWAKE: begin
                if ($countones({meters.hunger == METER_MAX, meters.bored == METER_MAX,
                                meters.filth == METER_MAX, meters.sick == METER_MAX}) >= 2) begin
                    state_n     = ST_DYING;
                    dying_cnt_n = '0;
                end else begin
                    if (tick) begin
                        if (hun_div == cnt_t'(RATE_HUNGER - 1)) begin
                            hun_div_n       = '0;
                            meters_n.hunger = sat_inc(meters.hunger, METER_MAX);
                        end else begin
                            hun_div_n = hun_div + cnt_t'(1);
                        end
                        if (bor_div == cnt_t'(RATE_BORED - 1)) begin
                            bor_div_n      = '0;
                            meters_n.bored = sat_inc(meters.bored, METER_MAX);
                        end else begin
                            bor_div_n = bor_div + cnt_t'(1);
                        end
                        if (fil_div == cnt_t'(RATE_FILTH - 1)) begin
                            fil_div_n      = '0;
                            meters_n.filth = sat_inc(meters.filth, METER_MAX);
                        end else begin
                            fil_div_n = fil_div + cnt_t'(1);
                        end
                        if (meters.filth == METER_MAX || meters.hunger == METER_MAX) begin
                            meters_n.sick = sat_inc(meters.sick, METER_MAX);
                        end
                        if (day_cnt == cnt_t'(DAY_TICKS - 1)) begin
                            day_cnt_n = '0;
                            state_n   = ST_ASLEEP;
                        end else begin
                            day_cnt_n = day_cnt + cnt_t'(1);
                        end
                    end
                    // Care clears are applied last so they override a same-cycle increment.
                    if (foodGiven)  meters_n.hunger = '0;
                    if (ballGiven)  meters_n.bored  = '0;
                    if (broomGiven) meters_n.filth  = '0;
                    if (pillsGiven) meters_n.sick   = '0;
                end
            end
            ST_ASLEEP: begin
                if (tick) begin
                    if (day_cnt == cnt_t'(SLEEP_TICKS - 1)) begin
                        day_cnt_n = '0;
                        age_n     = (age == 8'hFF) ? age : age + 8'd1;
                        state_n   = ST_AWAKE;
`ifdef PET_OLD_AGE_EN
                        if (age_n == MAX_AGE) begin
                            state_n = ST_DEAD;
                            dv_n    = 4'(DEATH_STAGES);
                        end
`endif
                    end else begin
                        day_cnt_n = day_cnt + cnt_t'(1);
                    end
                end
            end
            ST_DYING: begin
                if (firstAidGiven) begin
                    dv_n        = '0;
                    dying_cnt_n = '0;
                    meters_n    = {4{meter_t'(THRESH - 7'd1)}};
                    state_n     = ST_AWAKE;
                end else if (tick) begin
                    if (dying_cnt == cnt_t'(DYING_TICKS - 1)) begin
                        dying_cnt_n = '0;
                        dv_n        = deathValue + 4'd1;
                        if (dv_n == 4'(DEATH_STAGES)) state_n = ST_DEAD;
                    end else begin
                        dying_cnt_n = dying_cnt + cnt_t'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (state == ST_AWAKE && any_flag) begin
            if (tick) begin
                if (bub_cnt == cnt_t'(BUBBLE_TICKS - 1)) begin
                    bub_cnt_n = '0;
                    bubble_n  = 1'b1;
                end else begin
                    bub_cnt_n = bub_cnt + cnt_t'(1);
                end
            end
        end else begin
            bub_cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            meters       <= '0;
            hun_div      <= '0;
            bor_div      <= '0;
            fil_div      <= '0;
            day_cnt      <= '0;
            dying_cnt    <= '0;
            bub_cnt      <= '0;
            deathValue   <= '0;
            age          <= '0;
            sleep        <= 1'b0;
            hungry       <= 1'b0;
            boredom      <= 1'b0;
            filthy       <= 1'b0;
            illness      <= 1'b0;
            pet_dying    <= 1'b0;
            deceased     <= 1'b0;
            removeBubble <= 1'b0;
        end else begin
            state        <= state_n;
            meters       <= meters_n;
            hun_div      <= hun_div_n;
            bor_div      <= bor_div_n;
            fil_div      <= fil_div_n;
            day_cnt      <= day_cnt_n;
            dying_cnt    <= dying_cnt_n;
            bub_cnt      <= bub_cnt_n;
            deathValue   <= dv_n;
            age          <= age_n;
            sleep        <= (state_n == ST_ASLEEP);
            hungry       <= (meters_n.hunger >= THRESH);
            boredom      <= (meters_n.bored >= THRESH);
            filthy       <= (meters_n.filth >= THRESH);
            illness      <= (meters_n.sick >= THRESH);
            pet_dying    <= (state_n == ST_DYING);
            deceased     <= (state_n == ST_DEAD);
            removeBubble <= bubble_n;
        end
    end

endmodule

// File: tb/tb_pet_stats.sv
// Self-checking bench for pet_stats: a tick-level behavioural pet model is
// compared against every DUT output each cycle, plus hand-derived checkpoints.
module tb_pet_stats;

    localparam int TD   = 4;
    localparam int DAYT = 40;
    localparam int MMAX = 10;
    localparam int TH   = 6;
    localparam int RH   = 4;
    localparam int RB   = 6;
    localparam int RF   = 8;
    localparam int SLP  = 20;
    localparam int BUB  = 15;
    localparam int DYT  = 10;
`ifdef PET_OLD_AGE_EN
    localparam int MAXAGE = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0, foodGiven = 1'b0, ballGiven = 1'b0, broomGiven = 1'b0;
    logic pillsGiven = 1'b0, firstAidGiven = 1'b0;
    logic sleep, hungry, boredom, filthy, illness, pet_dying, deceased, removeBubble;
    logic [3:0] deathValue;
    logic [7:0] age;

    always #5 clk = ~clk;

    pet_stats #(
        .TICK_DIV  (TD),
        .DAY_TICKS (DAYT),
        .METER_MAX (7'd10),
        .THRESH    (7'd6)
`ifdef PET_OLD_AGE_EN
        ,
        .MAX_AGE   (8'd2)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .foodGiven     (foodGiven),
        .ballGiven     (ballGiven),
        .broomGiven    (broomGiven),
        .pillsGiven    (pillsGiven),
        .firstAidGiven (firstAidGiven),
        .sleep         (sleep),
        .hungry        (hungry),
        .boredom       (boredom),
        .filthy        (filthy),
        .illness       (illness),
        .pet_dying     (pet_dying),
        .deceased      (deceased),
        .deathValue    (deathValue),
        .removeBubble  (removeBubble),
        .age           (age)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string what);
        total++;
        bad++;
        $display("FAIL %s: actual=not reached required=reached t=%0t", what, $time);
    endtask

    // ---------------- behavioural model (one update per clk edge) ----------------
    typedef enum {M_IDLE, M_AWAKE, M_ASLEEP, M_DYING, M_DEAD} mode_e;
    mode_e mode = M_IDLE;
    int p = 0, n_aw = 0, day = 0, dtk = 0, dv = 0, age_m = 0, bub = 0, tick_no = 0;
    int h = 0, b = 0, f = 0, s = 0;
    logic e_sleep = 0, e_hungry = 0, e_boredom = 0, e_filthy = 0, e_illness = 0;
    logic e_dying = 0, e_dead = 0, e_bubble = 0;

    function automatic int up(input int v);
        return (v >= MMAX) ? MMAX : v + 1;
    endfunction

    always @(posedge clk) begin : model
        bit    tk, old_any, h_max, f_max;
        mode_e old_mode;
        int    nmax;
        if (reset) begin
            p = 0; mode = M_IDLE; n_aw = 0; day = 0; dtk = 0; dv = 0; age_m = 0; bub = 0;
            h = 0; b = 0; f = 0; s = 0;
            e_bubble = 0;
        end else begin
            tk = (p == TD - 1);
            p  = tk ? 0 : p + 1;
            if (tk) tick_no++;
            old_mode = mode;
            old_any  = e_hungry || e_boredom || e_filthy || e_illness;
            e_bubble = 0;
            case (mode)
                M_IDLE, M_DEAD: if (go) begin
                    mode = M_AWAKE; n_aw = 0; day = 0; dtk = 0; dv = 0; age_m = 0;
                    h = 0; b = 0; f = 0; s = 0;
                end
                M_AWAKE: begin
                    nmax = 0;
                    if (h == MMAX) nmax++;
                    if (b == MMAX) nmax++;
                    if (f == MMAX) nmax++;
                    if (s == MMAX) nmax++;
                    if (nmax >= 2) begin
                        mode = M_DYING; dtk = 0;
                    end else begin
                        if (tk) begin
                            h_max = (h == MMAX);
                            f_max = (f == MMAX);
                            n_aw++;
                            if (n_aw % RH == 0) h = up(h);
                            if (n_aw % RB == 0) b = up(b);
                            if (n_aw % RF == 0) f = up(f);
                            if (h_max || f_max) s = up(s);
                            day++;
                            if (day == DAYT) begin day = 0; mode = M_ASLEEP; end
                        end
                        if (foodGiven)  h = 0;
                        if (ballGiven)  b = 0;
                        if (broomGiven) f = 0;
                        if (pillsGiven) s = 0;
                    end
                end
                M_ASLEEP: if (tk) begin
                    day++;
                    if (day == SLP) begin
                        day = 0;
                        age_m = (age_m < 255) ? age_m + 1 : 255;
                        mode = M_AWAKE;
`ifdef PET_OLD_AGE_EN
                        if (age_m == MAXAGE) begin mode = M_DEAD; dv = 4; end
`endif
                    end
                end
                M_DYING: begin
                    if (firstAidGiven) begin
                        dv = 0; dtk = 0; h = TH - 1; b = TH - 1; f = TH - 1; s = TH - 1;
                        mode = M_AWAKE;
                    end else if (tk) begin
                        dtk++;
                        if (dtk == DYT) begin
                            dtk = 0; dv++;
                            if (dv == 4) mode = M_DEAD;
                        end
                    end
                end
                default: mode = M_IDLE;
            endcase
            if (old_mode == M_AWAKE && old_any) begin
                if (tk) begin
                    bub++;
                    if (bub == BUB) begin bub = 0; e_bubble = 1; end
                end
            end else begin
                bub = 0;
            end
        end
        e_sleep   = (mode == M_ASLEEP);
        e_hungry  = (h >= TH);
        e_boredom = (b >= TH);
        e_filthy  = (f >= TH);
        e_illness = (s >= TH);
        e_dying   = (mode == M_DYING);
        e_dead    = (mode == M_DEAD);
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("sleep",        sleep,        e_sleep);
            check("hungry",       hungry,       e_hungry);
            check("boredom",      boredom,      e_boredom);
            check("filthy",       filthy,       e_filthy);
            check("illness",      illness,      e_illness);
            check("pet_dying",    pet_dying,    e_dying);
            check("deceased",     deceased,     e_dead);
            check("deathValue",   deathValue,   dv);
            check("removeBubble", removeBubble, e_bubble);
            check("age",          age,          age_m);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // mask bits: 0 food, 1 ball, 2 broom, 3 pills, 4 first aid, 5 go
    task automatic pulse(input logic [5:0] m);
        {go, firstAidGiven, pillsGiven, broomGiven, ballGiven, foodGiven} = m;
        step();
        {go, firstAidGiven, pillsGiven, broomGiven, ballGiven, foodGiven} = '0;
    endtask

    task automatic wait_awake(input int tgt, input string what);
        int k = 0;
        while (n_aw != tgt && k < 2000) begin step(); k++; end
        if (n_aw != tgt) timeout(what);
    endtask

    function automatic logic cur_sig(input int id);
        case (id)
            0:       return sleep;
            1:       return pet_dying;
            default: return deceased;
        endcase
    endfunction

    task automatic wait_sig(input int id, input logic val, input int budget, input string what);
        int k = 0;
        while (cur_sig(id) !== val && k < budget) begin step(); k++; end
        if (cur_sig(id) !== val) timeout(what);
    endtask

    task automatic wait_dv(input int val, input string what);
        int k = 0;
        while (deathValue != 4'(val) && k < 200) begin step(); k++; end
        if (deathValue != 4'(val)) timeout(what);
    endtask

    function automatic logic [31:0] all_outs();
        return {12'd0, sleep, hungry, boredom, filthy, illness, pet_dying, deceased,
                removeBubble, deathValue, age};
    endfunction

    initial begin : stim
        int t0;
        int t_prev;
        int k;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        check("reset_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        step(); step();
        check("idle_outputs", all_outs(), 32'd0);

        // Test 1: hungry after the 24th tick, cleared by food
        pulse(6'b100000);
        wait_awake(23, "awake tick 23");
        check("hungry_before_24", hungry, 1'b0);
        wait_awake(24, "awake tick 24");
        check("hungry_at_24", hungry, 1'b1);
        check("boredom_at_24", boredom, 1'b0);
        pulse(6'b000001);
        check("hungry_after_food", hungry, 1'b0);

        // Test 2: food lands on the cycle of the tick-28 hunger increment
        k = 0;
        while (!(n_aw == 27 && p == TD - 1) && k < 500) begin step(); k++; end
        if (!(n_aw == 27 && p == TD - 1)) timeout("tick 28 alignment");
        pulse(6'b000001);

        // Test 5: day ends after 40 awake ticks, night lasts 20 ticks
        wait_awake(40, "awake tick 40");
        t0 = tick_no;
        check("sleep_at_day_end", sleep, 1'b1);
        check("boredom_at_day_end", boredom, 1'b1);
        check("age_before_wake", age, 8'd0);
        pulse(6'b001001);
        wait_sig(0, 1'b0, 400, "wake up");
        check("night_ticks", tick_no - t0, 20);
        check("age_after_wake", age, 8'd1);
        wait_awake(51, "awake tick 51");
        check("hungry_at_51", hungry, 1'b0);
        wait_awake(52, "awake tick 52");
        check("hungry_at_52", hungry, 1'b1);

        // Test 3: starve to death, deathValue steps every 10 ticks
        wait_sig(1, 1'b1, 1000, "pet_dying rise");
        check("dv_on_dying", deathValue, 4'd0);
        check("deceased_on_dying", deceased, 1'b0);
        t_prev = tick_no;
        for (int i = 1; i <= 4; i++) begin
            wait_dv(i, "deathValue step");
            check("dv_interval", tick_no - t_prev, DYT);
            t_prev = tick_no;
        end
        check("deceased_at_4", deceased, 1'b1);
        check("dying_off_at_4", pet_dying, 1'b0);
        pulse(6'b100000);
        check("restart_age", age, 8'd0);
        check("restart_deceased", deceased, 1'b0);
        check("restart_dv", deathValue, 4'd0);

        // Test 4: first aid at deathValue 2 revives with meters at THRESH-1
        wait_sig(1, 1'b1, 1000, "second dying");
        check("dying_hungry", hungry, 1'b1);
        check("dying_illness", illness, 1'b1);
        wait_dv(2, "deathValue 2");
        pulse(6'b010000);
        check("revive_dv", deathValue, 4'd0);
        check("revive_dying", pet_dying, 1'b0);
        check("revive_flags", {hungry, boredom, filthy, illness, sleep}, 5'd0);
        wait_awake(n_aw + RH, "post revive hunger");
        check("hungry_after_revive", hungry, 1'b1);

        // Reset in the middle of DYING
        wait_sig(1, 1'b1, 1000, "third dying");
        reset = 1'b1;
        step();
        check("reset_mid_dying", all_outs(), 32'd0);
        reset = 1'b0;
        step();

`ifdef PET_OLD_AGE_EN
        // Test 6: well-cared pet dies of old age on the second wake-up
        pulse(6'b100000);
        k = 0;
        while (!deceased && k < 1500) begin
            if (k % 32 == 0) pulse(6'b001111);
            else step();
            k++;
        end
        if (!deceased) timeout("old-age death");
        check("old_age_deceased", deceased, 1'b1);
        check("old_age_dv", deathValue, 4'd4);
        check("old_age_sleep", sleep, 1'b0);
`endif

        step();
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
